// File: rtl/aq_djpeg_hdrgen.sv
// JPEG baseline header generator: on Start emits SOI, DQT, DHT, SOF0 and SOS
// (tables fetched from an external RAM); on EoiReq emits EOI (FF D9).
// Latency: first byte valid 1 cycle after Start; constant bytes 1/cycle,
// table bytes 1 per 2 cycles.
// Backpressure: OutData/OutValid/OutLast are held while OutValid&!OutReady,
// and no table read is issued while that byte is still waiting.
// Ports: rst/clk (async active-low reset); Start/EoiReq/Width/Height/Comp
// from encoder control; TblRead/TblAddr/TblData to the table RAM;
// OutValid/OutData/OutLast/OutReady to the byte packer; Busy/Done status.
module aq_djpeg_hdrgen (
  input  logic        rst,
  input  logic        clk,
  input  logic        Start,
  input  logic        EoiReq,
  input  logic [15:0] Width,
  input  logic [15:0] Height,
  input  logic [2:0]  Comp,
  output logic        TblRead,
  output logic [10:0] TblAddr,
  input  logic [7:0]  TblData,
  output logic        OutValid,
  output logic [7:0]  OutData,
  output logic        OutLast,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOI, S_DQT_HDR, S_DQT_FETCH, S_DQT_EMIT, S_DHT_SCAN, S_DHT_HDR,
    S_DHT_FETCH, S_DHT_EMIT, S_SOF, S_SOS, S_EOI, S_FIN
  } state_t;

  state_t      state;
  logic [4:0]  idx;       // byte index within a constant sequence
  logic [7:0]  tbi;       // table byte index
  logic [1:0]  sel;       // table select (DQT t or DHT k)
  logic [11:0] sum;       // S: number of Huffman values in current table
  logic        rd_pend;   // a count read was issued last cycle
  logic [15:0] width_q;
  logic [15:0] height_q;
  logic        comp3;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        can_load;
  logic [15:0] seg_len;
  logic [7:0]  cbyte;
  logic        clast;

  // Output register may take a new byte when empty or being drained now.
  assign can_load = !out_valid || OutReady;
  assign seg_len  = {4'b0, sum} + 16'd19;

  assign TblRead = can_load && ((state == S_DQT_FETCH) || (state == S_DHT_FETCH) ||
                                ((state == S_DHT_SCAN) && (tbi < 8'd16)));

  // DHT values live at base+16+i with i wrapping in 8 bits, which is just
  // the 8-bit table byte index over the whole count+value stream.
  always_comb begin
    TblAddr = 11'd0;
    case (state)
      S_DQT_FETCH: TblAddr = {4'b0, sel[0], tbi[5:0]};
      S_DHT_SCAN,
      S_DHT_FETCH: TblAddr = {({1'b0, sel} + 3'd1), tbi};
      default:     TblAddr = 11'd0;
    endcase
  end

  // Constant / computed header bytes indexed by idx.
  always_comb begin
    cbyte = 8'h00;
    clast = 1'b0;
    case (state)
      S_SOI: begin
        cbyte = (idx == 5'd0) ? 8'hFF : 8'hD8;
        clast = (idx == 5'd1);
      end
      S_EOI: begin
        cbyte = (idx == 5'd0) ? 8'hFF : 8'hD9;
        clast = (idx == 5'd1);
      end
      S_DQT_HDR: begin
        case (idx)
          5'd0:    cbyte = 8'hFF;
          5'd1:    cbyte = 8'hDB;
          5'd2:    cbyte = 8'h00;
          5'd3:    cbyte = 8'h43;
          default: cbyte = {6'b0, sel};
        endcase
        clast = (idx == 5'd4);
      end
      S_DHT_HDR: begin
        case (idx)
          5'd0:    cbyte = 8'hFF;
          5'd1:    cbyte = 8'hC4;
          5'd2:    cbyte = seg_len[15:8];
          5'd3:    cbyte = seg_len[7:0];
          default: cbyte = {3'b0, sel[0], 3'b0, sel[1]};  // Tc/Th
        endcase
        clast = (idx == 5'd4);
      end
      S_SOF: begin
        case (idx)
          5'd0:  cbyte = 8'hFF;
          5'd1:  cbyte = 8'hC0;
          5'd2:  cbyte = 8'h00;
          5'd3:  cbyte = comp3 ? 8'h11 : 8'h0B;
          5'd4:  cbyte = 8'h08;
          5'd5:  cbyte = height_q[15:8];
          5'd6:  cbyte = height_q[7:0];
          5'd7:  cbyte = width_q[15:8];
          5'd8:  cbyte = width_q[7:0];
          5'd9:  cbyte = comp3 ? 8'h03 : 8'h01;
          5'd10: cbyte = 8'h01;
          5'd11: cbyte = comp3 ? 8'h22 : 8'h11;
          5'd12: cbyte = 8'h00;
          5'd13: cbyte = 8'h02;
          5'd14: cbyte = 8'h11;
          5'd15: cbyte = 8'h01;
          5'd16: cbyte = 8'h03;
          5'd17: cbyte = 8'h11;
          default: cbyte = 8'h01;
        endcase
        clast = comp3 ? (idx == 5'd18) : (idx == 5'd12);
      end
      S_SOS: begin
        if (comp3) begin
          case (idx)
            5'd0:  cbyte = 8'hFF;
            5'd1:  cbyte = 8'hDA;
            5'd2:  cbyte = 8'h00;
            5'd3:  cbyte = 8'h0C;
            5'd4:  cbyte = 8'h03;
            5'd5:  cbyte = 8'h01;
            5'd6:  cbyte = 8'h00;
            5'd7:  cbyte = 8'h02;
            5'd8:  cbyte = 8'h11;
            5'd9:  cbyte = 8'h03;
            5'd10: cbyte = 8'h11;
            5'd12: cbyte = 8'h3F;
            default: cbyte = 8'h00;
          endcase
          clast = (idx == 5'd13);
        end else begin
          case (idx)
            5'd0:  cbyte = 8'hFF;
            5'd1:  cbyte = 8'hDA;
            5'd3:  cbyte = 8'h08;
            5'd4:  cbyte = 8'h01;
            5'd5:  cbyte = 8'h01;
            5'd8:  cbyte = 8'h3F;
            default: cbyte = 8'h00;
          endcase
          clast = (idx == 5'd9);
        end
      end
      default: begin
        cbyte = 8'h00;
        clast = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= 5'd0;
      tbi       <= 8'd0;
      sel       <= 2'd0;
      sum       <= 12'd0;
      rd_pend   <= 1'b0;
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      comp3     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= TblRead && (state == S_DHT_SCAN);
      if (out_valid && OutReady) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          // The Done cycle still reads as idle; requests there are dropped.
          if (!done && Start) begin
            width_q   <= Width;
            height_q  <= Height;
            comp3     <= (Comp != 3'd1);
            sel       <= 2'd0;
            tbi       <= 8'd0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= 8'hFF;
            idx       <= 5'd1;
            state     <= S_SOI;
          end else if (!done && EoiReq) begin
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= 8'hFF;
            idx       <= 5'd1;
            state     <= S_EOI;
          end
        end
        S_SOI, S_DQT_HDR, S_DHT_HDR, S_SOF, S_SOS, S_EOI: begin
          if (can_load) begin
            out_valid <= 1'b1;
            out_data  <= cbyte;
            out_last  <= clast && ((state == S_SOS) || (state == S_EOI));
            idx       <= idx + 5'd1;
            if (clast) begin
              idx <= 5'd0;
              tbi <= 8'd0;
              case (state)
                S_SOI:     state <= S_DQT_HDR;
                S_DQT_HDR: state <= S_DQT_FETCH;
                S_DHT_HDR: state <= S_DHT_FETCH;
                S_SOF:     state <= S_SOS;
                default:   state <= S_FIN;
              endcase
            end
          end
        end
        S_DQT_FETCH: if (can_load) state <= S_DQT_EMIT;
        S_DQT_EMIT: begin
          // Register is free here: the read was only issued when it could drain.
          out_valid <= 1'b1;
          out_data  <= TblData;
          tbi       <= tbi + 8'd1;
          state     <= S_DQT_FETCH;
          if (tbi == 8'd63) begin
            if (sel == (comp3 ? 2'd1 : 2'd0)) begin
              sel   <= 2'd0;
              tbi   <= 8'd0;
              sum   <= 12'd0;
              state <= S_DHT_SCAN;
            end else begin
              sel   <= sel + 2'd1;
              idx   <= 5'd0;
              state <= S_DQT_HDR;
            end
          end
        end
        S_DHT_SCAN: begin
          if (rd_pend) sum <= sum + {4'b0, TblData};
          if (TblRead) tbi <= tbi + 8'd1;
          // Last count arrives the cycle after the 16th read.
          if ((tbi == 8'd16) && rd_pend) begin
            idx   <= 5'd0;
            state <= S_DHT_HDR;
          end
        end
        S_DHT_FETCH: if (can_load) state <= S_DHT_EMIT;
        S_DHT_EMIT: begin
          out_valid <= 1'b1;
          out_data  <= TblData;
          tbi       <= tbi + 8'd1;
          state     <= S_DHT_FETCH;
          if ({4'b0, tbi} == (sum + 12'd15)) begin
            idx <= 5'd0;
            if (sel == (comp3 ? 2'd3 : 2'd1)) begin
              state <= S_SOF;
            end else begin
              sel   <= sel + 2'd1;
              tbi   <= 8'd0;
              sum   <= 12'd0;
              state <= S_DHT_SCAN;
            end
          end
        end
        S_FIN: begin
          if (out_valid && OutReady) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign OutValid = out_valid;
  assign OutData  = out_data;
  assign OutLast  = out_last;
  assign Busy     = busy;
  assign Done     = done;

endmodule

// File: tb/tb_aq_djpeg_hdrgen.sv
// Directed bench for aq_djpeg_hdrgen: table RAM model, byte capture monitor,
// expected header stream built from the same table contents.
module tb_aq_djpeg_hdrgen;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, Start, EoiReq;
  logic [15:0] Width, Height;
  logic [2:0]  Comp;
  logic        TblRead;
  logic [10:0] TblAddr;
  logic [7:0]  TblData = 8'h00;
  logic        OutValid;
  logic [7:0]  OutData;
  logic        OutLast;
  logic        OutReady = 1'b1;
  logic        Busy, Done;

  aq_djpeg_hdrgen dut (
    .rst(rst), .clk(clk), .Start(Start), .EoiReq(EoiReq), .Width(Width),
    .Height(Height), .Comp(Comp), .TblRead(TblRead), .TblAddr(TblAddr),
    .TblData(TblData), .OutValid(OutValid), .OutData(OutData),
    .OutLast(OutLast), .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  logic [7:0] mem [0:2047];
  logic [7:0] cnt [4][16];
  always @(posedge clk) if (TblRead) TblData <= mem[TblAddr];

  int nchk = 0;
  int nfail = 0;
  logic [7:0] cap_dat[$];
  logic       cap_last[$];
  logic [7:0] exp_q[$];
  int cyc = 0, last_cyc = -1, done_cyc = -1, viol = 0, addr_bad = 0, hold_cnt = 0;
  bit addr_watch = 0, rnd_mode = 0, hold = 0;
  logic [7:0] hold_dat = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready driver: always ready, or a coin flip per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      OutReady = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (hold) begin
        hold_cnt++;
        check("hold_stable", {23'd0, OutValid, OutData}, {23'd0, 1'b1, hold_dat});
      end
      if (TblRead && OutValid && !OutReady) viol++;
      if (addr_watch && TblRead && (((TblAddr >= 11'd64) && (TblAddr < 11'd256)) || (TblAddr >= 11'd768)))
        addr_bad++;
      if (OutValid && OutReady) begin
        cap_dat.push_back(OutData);
        cap_last.push_back(OutLast);
        if (OutLast) last_cyc = cyc;
      end
      if (Done) done_cyc = cyc;
      hold = OutValid && !OutReady;
      hold_dat = OutData;
    end else begin
      hold = 0;
    end
  end

  task automatic clear_cap();
    cap_dat.delete();
    cap_last.delete();
    last_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic build_exp(input logic [2:0] c, input logic [15:0] w, input logic [15:0] h);
    bit c3;
    int nq, nh, s, base, len;
    logic [7:0] n;
    c3 = (c != 3'd1);
    nq = c3 ? 2 : 1;
    nh = c3 ? 4 : 2;
    n  = c3 ? 8'd3 : 8'd1;
    exp_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hD8);
    for (int t = 0; t < nq; t++) begin
      exp_q.push_back(8'hFF); exp_q.push_back(8'hDB); exp_q.push_back(8'h00);
      exp_q.push_back(8'h43); exp_q.push_back(8'(t));
      for (int j = 0; j < 64; j++) exp_q.push_back(mem[t*64+j]);
    end
    for (int k = 0; k < nh; k++) begin
      base = 256 + k*256;
      s = 0;
      for (int j = 0; j < 16; j++) s += int'(mem[base+j]);
      len = 19 + s;
      exp_q.push_back(8'hFF); exp_q.push_back(8'hC4);
      exp_q.push_back(8'(len >> 8)); exp_q.push_back(8'(len));
      exp_q.push_back((k == 0) ? 8'h00 : (k == 1) ? 8'h10 : (k == 2) ? 8'h01 : 8'h11);
      for (int j = 0; j < 16 + s; j++) exp_q.push_back(mem[base + (j % 256)]);
    end
    exp_q.push_back(8'hFF); exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
    exp_q.push_back(8'd8 + 8'd3*n); exp_q.push_back(8'h08);
    exp_q.push_back(h[15:8]); exp_q.push_back(h[7:0]);
    exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]); exp_q.push_back(n);
    if (c3) begin
      exp_q.push_back(8'h01); exp_q.push_back(8'h22); exp_q.push_back(8'h00);
      exp_q.push_back(8'h02); exp_q.push_back(8'h11); exp_q.push_back(8'h01);
      exp_q.push_back(8'h03); exp_q.push_back(8'h11); exp_q.push_back(8'h01);
    end else begin
      exp_q.push_back(8'h01); exp_q.push_back(8'h11); exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'hFF); exp_q.push_back(8'hDA); exp_q.push_back(8'h00);
    exp_q.push_back(8'd6 + 8'd2*n); exp_q.push_back(n);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    if (c3) begin
      exp_q.push_back(8'h02); exp_q.push_back(8'h11);
      exp_q.push_back(8'h03); exp_q.push_back(8'h11);
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
  endtask

  task automatic compare_stream(input string tag);
    int nmis, nl, first;
    nmis = 0; nl = 0; first = -1;
    check({tag, "_len"}, cap_dat.size(), exp_q.size());
    for (int i = 0; i < cap_dat.size() && i < exp_q.size(); i++)
      if (cap_dat[i] !== exp_q[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    check($sformatf("%s_bytes(first bad idx %0d)", tag, first), nmis, 0);
    for (int i = 0; i < cap_last.size(); i++) if (cap_last[i]) nl++;
    check({tag, "_last_count"}, nl, 1);
    check({tag, "_last_on_final"}, (cap_last.size() > 0) ? 32'(cap_last[cap_last.size()-1]) : 32'd0, 1);
  endtask

  task automatic spot(input int i, input logic [7:0] e);
    logic [7:0] o;
    o = (i < cap_dat.size()) ? cap_dat[i] : 8'hxx;
    check($sformatf("byte[%0d]", i), {24'd0, o}, {24'd0, e});
  endtask

  task automatic kick(input logic [2:0] c, input logic [15:0] w, input logic [15:0] h, input bit with_eoi);
    @(posedge clk);
    #1;
    Comp = c; Width = w; Height = h; Start = 1'b1; EoiReq = with_eoi;
    @(posedge clk);
    #1;
    Start = 1'b0; EoiReq = 1'b0;
    Width = 16'hDEAD; Height = 16'hBEEF; Comp = (c == 3'd1) ? 3'd3 : 3'd1;
    check("first_valid", OutValid, 1);
    check("first_byte", OutData, 8'hFF);
    check("busy_rise", Busy, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done && n < budget);
    check({tag, "_done_seen"}, Done, 1);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 2048; a++) mem[a] = 8'((a * 37) ^ (a >> 5));
    cnt = '{'{8'h00,8'h01,8'h05,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
            '{8'h00,8'h02,8'h01,8'h03,8'h03,8'h02,8'h04,8'h03,8'h05,8'h05,8'h04,8'h04,8'h00,8'h00,8'h01,8'h7D},
            '{8'h00,8'h03,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00},
            '{8'h00,8'h02,8'h01,8'h02,8'h04,8'h04,8'h03,8'h04,8'h07,8'h05,8'h04,8'h04,8'h00,8'h01,8'h02,8'h77}};
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 16; j++) mem[256 + k*256 + j] = cnt[k][j];

    rst = 1'b0; Start = 1'b0; EoiReq = 1'b0;
    Width = 16'd0; Height = 16'd0; Comp = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_OutValid", OutValid, 0);
    check("rst_OutData", OutData, 0);
    check("rst_OutLast", OutLast, 0);
    check("rst_TblRead", TblRead, 0);
    check("rst_TblAddr", TblAddr, 0);
    check("rst_Busy", Busy, 0);
    check("rst_Done", Done, 0);
    @(negedge clk);
    rst = 1'b1;

    // A: 3 components, 640x480, always ready; Start in Done cycle ignored.
    clear_cap();
    build_exp(3'd3, 16'd640, 16'd480);
    kick(3'd3, 16'd640, 16'd480, 1'b0);
    wait_done(4000, "A");
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    check("A_done_one_cycle", Done, 0);
    check("A_busy_fall", Busy, 0);
    repeat (10) @(negedge clk);
    compare_stream("A");
    check("A_done_timing", done_cyc, last_cyc + 1);
    spot(0, 8'hFF); spot(1, 8'hD8); spot(2, 8'hFF); spot(3, 8'hDB);
    spot(4, 8'h00); spot(5, 8'h43); spot(6, 8'h00); spot(75, 8'h01);
    spot(142, 8'h00); spot(143, 8'h1F); spot(144, 8'h00);
    spot(175, 8'h00); spot(176, 8'hB5); spot(177, 8'h10);
    spot(359, 8'h1F); spot(360, 8'h01); spot(393, 8'h11);
    spot(572, 8'hFF); spot(573, 8'hC0); spot(574, 8'h00); spot(575, 8'h11);
    spot(576, 8'h08); spot(577, 8'h01); spot(578, 8'hE0); spot(579, 8'h02);
    spot(580, 8'h80); spot(581, 8'h03); spot(591, 8'hFF); spot(592, 8'hDA);
    spot(594, 8'h0C); spot(604, 8'h00);

    // B: grey 8x8; Start/EoiReq while busy must do nothing.
    clear_cap();
    addr_watch = 1;
    build_exp(3'd1, 16'd8, 16'd8);
    kick(3'd1, 16'd8, 16'd8, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    Start = 1'b1; EoiReq = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0; EoiReq = 1'b0;
    wait_done(3000, "B");
    addr_watch = 0;
    repeat (10) @(negedge clk);
    compare_stream("B");
    check("B_addr_range", addr_bad, 0);
    spot(287, 8'hFF); spot(288, 8'hC0); spot(289, 8'h00); spot(290, 8'h0B);
    spot(292, 8'h00); spot(293, 8'h08); spot(296, 8'h01); spot(297, 8'h01);
    spot(298, 8'h11); spot(299, 8'h00); spot(300, 8'hFF); spot(301, 8'hDA);
    spot(303, 8'h08); spot(304, 8'h01); spot(309, 8'h00);

    // C: same as A with random backpressure.
    clear_cap();
    rnd_mode = 1;
    hold_cnt = 0;
    build_exp(3'd3, 16'd640, 16'd480);
    kick(3'd3, 16'd640, 16'd480, 1'b0);
    wait_done(10000, "C");
    rnd_mode = 0;
    repeat (5) @(negedge clk);
    compare_stream("C");
    check("C_stalls_seen", hold_cnt > 0, 1);
    check("no_read_while_stalled", viol, 0);

    // D: EOI from idle; a Start during it is ignored.
    clear_cap();
    @(posedge clk);
    #1;
    EoiReq = 1'b1;
    @(posedge clk);
    #1;
    EoiReq = 1'b0;
    check("D_first_valid", OutValid, 1);
    check("D_first_byte", OutData, 8'hFF);
    check("D_busy", Busy, 1);
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done(50, "D");
    repeat (10) @(negedge clk);
    check("D_len", cap_dat.size(), 2);
    spot(0, 8'hFF); spot(1, 8'hD9);
    check("D_last0", (cap_last.size() > 0) ? 32'(cap_last[0]) : 32'hx, 0);
    check("D_last1", (cap_last.size() > 1) ? 32'(cap_last[1]) : 32'hx, 1);
    check("D_done_timing", done_cyc, last_cyc + 1);

    // E: reset after 100 bytes, then regenerate.
    clear_cap();
    kick(3'd3, 16'd640, 16'd480, 1'b0);
    n = 0;
    while (cap_dat.size() < 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("E_reached_100", cap_dat.size() >= 100, 1);
    #2;
    rst = 1'b0;
    #1;
    check("E_rst_OutValid", OutValid, 0);
    check("E_rst_Busy", Busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("E_no_resume", OutValid, 0);
    check("E_idle_busy", Busy, 0);
    clear_cap();
    build_exp(3'd3, 16'd640, 16'd480);
    kick(3'd3, 16'd640, 16'd480, 1'b0);
    wait_done(4000, "E");
    repeat (5) @(negedge clk);
    compare_stream("E");
    spot(0, 8'hFF); spot(1, 8'hD8);

    // F: Start and EoiReq together -> header only.
    clear_cap();
    build_exp(3'd3, 16'd640, 16'd480);
    kick(3'd3, 16'd640, 16'd480, 1'b1);
    wait_done(4000, "F");
    repeat (10) @(negedge clk);
    compare_stream("F");
    spot(604, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/aq_djpeg_hdrgen.md
# aq_djpeg_hdrgen

JPEG baseline header generator: the writer-side counterpart of the decoder's marker parser. On a start pulse it emits a byte stream for the complete JFIF-less header: SOI, DQT, DHT, SOF0 and SOS. Quantization and Huffman table bytes are fetched from an external table RAM, and the stream ends at the start of entropy-coded data. A separate request emits EOI after the encoder's entropy-coded data. It sits between the encoder control and the output byte packer, ahead of the entropy coder's mux.

## Interface
Parameters: none.
- rst  in  1  asynchronous active-low reset
- clk  in  1  clock
- Start  in  1  one-cycle pulse; latches Width/Height/Comp; ignored unless idle
- EoiReq  in  1  one-cycle pulse; emits FF D9; ignored unless idle
- Width  in  16  image width, pixels
- Height  in  16  image height, pixels
- Comp  in  3  component count; 1 = grey, any other value = 3 (YCbCr 4:2:0)
- TblRead  out  1  table RAM read strobe
- TblAddr  out  11  table RAM address
- TblData  in  8  read data, valid the cycle after TblRead
- OutValid  out  1  byte valid
- OutData  out  8  header byte
- OutLast  out  1  with last SOS byte or with D9 of EOI
- OutReady  in  1  downstream accepts when OutValid&OutReady
- Busy  out  1  sequence in progress
- Done  out  1  one-cycle pulse after last byte accepted

## Operation
- Table RAM map:
  - DQT table t (t=0,1): 64 bytes in zigzag order at t*64.
  - DHT table k: base 256+k*256. Bytes 0..15 hold code counts; values start at byte 16.
  - k order: 0=DC0 (Tc/Th 0x00), 1=AC0 (0x10), 2=DC1 (0x01), 3=AC1 (0x11).
- Emission order:
  - SOI: FF D8.
  - DQT, one segment per table: FF DB 00 43, then Pq/Tq byte = t, then 64 table bytes. Tables 0,1 for Comp=3; table 0 only for Comp=1.
  - DHT, one segment per table: FF C4, Lh Ll = 19+S, Tc/Th byte, 16 counts, S values. S = sum of the 16 counts. Tables 0..3 for Comp=3; tables 0,1 for Comp=1.
  - SOF0: FF C0, then 00 (8+3N), 08, Height[15:8] Height[7:0], Width[15:8] Width[7:0], N, then per component:
    - Comp=3: 01 22 00 / 02 11 01 / 03 11 01.
    - Comp=1: 01 11 00.
  - SOS: FF DA, then 00 (6+2N), N, then per component 01 00 / 02 11 / 03 11, then 00 3F 00. OutLast is asserted with the final 00.
- DHT scan: before each DHT segment, read the 16 counts (16 fetches) and accumulate S in 12 bits. S ≤ 240 is in contract. Value address = base+16+i, 8-bit i, wraps within the 256-byte window.
- States:
  - Idle → Soi → DqtHdr → DqtFetch ↔ DqtEmit (×64).
  - Next table or DhtScan → DhtHdr → DhtFetch ↔ DhtEmit (16+S).
  - Next table or Sof → Sos → Idle.
  - Idle → Eoi → Idle.
- Counters:
  - Byte index within a constant sequence: 5 bits.
  - Table byte index: 8 bits.
  - Table select: 2 bits.

## Timing
- Reset values: OutValid 0, OutData 00, OutLast 0, TblRead 0, TblAddr 0, Busy 0, Done 0. All internal state is reset to Idle. Reset mid-sequence aborts with no further bytes.
- OutData, OutValid and OutLast are registered. A byte is held unchanged while OutValid&!OutReady. The next byte is loaded only on acceptance or when OutValid=0.
- Constant and computed bytes: up to 1 byte per cycle with OutReady held high.
- Table bytes: TblRead asserted for one cycle; TblData is captured the next cycle and presented. Throughput is at most 1 byte per 2 cycles. No read is issued while the output register is full and unaccepted.
- Start to first OutValid: 1 cycle. Busy rises the cycle after Start and falls with Done.
- Done: high one cycle after the last SOS byte is accepted (or D9 is accepted). Start or EoiReq arriving in that cycle is ignored.
- Simultaneous Start and EoiReq in Idle: Start wins; EoiReq is dropped.
- Width/Height/Comp changes after Start have no effect until the next Start.

## Test plan
- Comp=3, 640x480, Annex K tables (DC sums 12, AC sums 162), OutReady=1 -> 605 bytes.
  - Bytes: FF D8 FF DB 00 43 00 …; DHT lengths 00 1F / 00 B5.
  - SOF: FF C0 00 11 08 01 E0 02 80 03 …
  - Last byte 00 with OutLast; Done 1 cycle later.
- Comp=1, 8x8, same tables -> 310 bytes. SOF length 00 0B, SOS length 00 08 with N=01. No TblAddr ≥ 64 in the DQT range and none ≥ 768 are issued.
- Same as the first test with OutReady pseudo-random 50% -> identical 605-byte sequence; OutData stable whenever OutValid&!OutReady.
- EoiReq in Idle -> FF D9, OutLast on D9, Done pulse. EoiReq or Start while Busy -> no effect.
- Reset asserted after the 100th byte -> OutValid=0 and Busy=0 immediately. A subsequent Start regenerates from FF D8.
- Start and EoiReq in the same cycle -> header sequence only, no D9.
